// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; formats GRF write data with byte/halfword load extension.
module mem_wb_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] PC_M,
  input  logic [31:0] ALUout_M,
  input  logic [31:0] DMout_M,
  input  logic [4:0]  A3_M,
  input  logic        RegWrite_M,
  input  logic [1:0]  WDSel_M,
  input  logic [2:0]  LoadType_M,
  output logic [31:0] PC_W,
  output logic [4:0]  A3_W,
  output logic        RegWrite_W,
  output logic [31:0] WD_W,
  output logic [1:0]  Tnew_W
);
  logic [31:0] pc_q, alu_q, dm_q, pc_d, alu_d, dm_d;
  logic [4:0]  a3_q, a3_d;
  logic        rw_q, rw_d;
  logic [1:0]  ws_q, ws_d;
  logic [2:0]  lt_q, lt_d;
  logic [31:0] byte_sh, half_sh, mem_wd;
  logic [7:0]  by;
  logic [15:0] hw;
  // A flush captures an all-zero bubble; reset overrides it with the same bubble.
  always_comb begin
    pc_d  = flush ? '0 : PC_M;
    alu_d = flush ? '0 : ALUout_M;
    dm_d  = flush ? '0 : DMout_M;
    a3_d  = flush ? '0 : A3_M;
    rw_d  = flush ? 1'b0 : RegWrite_M;
    ws_d  = flush ? '0 : WDSel_M;
    lt_d  = flush ? '0 : LoadType_M;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      alu_q <= '0;
      dm_q  <= '0;
      a3_q  <= '0;
      rw_q  <= 1'b0;
      ws_q  <= '0;
      lt_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      alu_q <= alu_d;
      dm_q  <= dm_d;
      a3_q  <= a3_d;
      rw_q  <= rw_d;
      ws_q  <= ws_d;
      lt_q  <= lt_d;
    end
  end
  // Halfword select ignores offset bit 0; misalignment is not trapped here.
  always_comb begin
    byte_sh = dm_q >> {alu_q[1:0], 3'b000};
    half_sh = dm_q >> {alu_q[1], 4'b0000};
    by      = byte_sh[7:0];
    hw      = half_sh[15:0];
    mem_wd  = lt_q == 3'd1 ? {24'b0, by} :
              lt_q == 3'd2 ? {{24{by[7]}}, by} :
              lt_q == 3'd3 ? {16'b0, hw} :
              lt_q == 3'd4 ? {{16{hw[15]}}, hw} : dm_q;
    WD_W    = ws_q == 2'd0 ? alu_q :
              ws_q == 2'd1 ? mem_wd :
              ws_q == 2'd2 ? pc_q + 32'd8 : '0;
  end
  assign PC_W       = pc_q;
  assign A3_W       = a3_q;
  assign RegWrite_W = rw_q & (a3_q != 5'd0);
  assign Tnew_W     = 2'd0;
endmodule

// File: doc/mem_wb_reg.md
# mem_wb_reg

MEM/WB pipeline register and write-back data formatter for the five-stage MIPS core. It captures the memory-stage results each clock, including the data-memory read word, ALU result, link PC, destination register and control. In the W stage it produces the final register-file write data, applying byte/halfword load extension from the registered address offset. Its outputs drive the GRF write port and the W-stage forwarding path.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears every register on the rising edge where it is high
- flush  input  1  synchronous; loads a bubble (all-zero register) instead of the M-stage values
- PC_M  input  32  PC of the instruction in M
- ALUout_M  input  32  ALU result; also the data-memory address
- DMout_M  input  32  word read from data memory at {ALUout_M[31:2],2'b00}
- A3_M  input  5  destination register number
- RegWrite_M  input  1  instruction writes the GRF
- WDSel_M  input  2  write-data source: 0 ALU, 1 memory, 2 PC+8, 3 reserved
- LoadType_M  input  3  0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh, 5–7 treated as lw
- PC_W  output  32  registered PC (for GRF write trace)
- A3_W  output  5  registered destination register
- RegWrite_W  output  1  GRF write enable
- WD_W  output  32  formatted GRF write data
- Tnew_W  output  2  always 0 (forwarding-unit convention); kept as a port for uniformity

## Operation
- On every rising edge without reset or flush, latch PC_M, ALUout_M, DMout_M, A3_M, RegWrite_M, WDSel_M and LoadType_M into W registers. There is no enable; this stage never stalls.
- reset has priority over flush. Both load all-zero registers, so the stage holds a bubble.
- RegWrite_W = RegWrite_reg & (A3_reg != 0). Writes to $0 are never asserted.
- WD_W is combinational from the W registers:
  - WDSel 0 → ALUout_reg.
  - WDSel 2 → PC_reg + 8, 32-bit wrap-around (0xFFFFFFFC + 8 = 0x00000004).
  - WDSel 3 → 0.
  - WDSel 1 → memory word formatted using off = ALUout_reg[1:0]:
    - lw: the whole word, regardless of off.
    - lbu / lb: byte DMout_reg[8*off+7 : 8*off], zero- or sign-extended respectively.
    - lhu / lh: half DMout_reg[16*off[1]+15 : 16*off[1]], zero- or sign-extended. off[0] is ignored; misaligned halfword access is not trapped here.
- Little-endian byte numbering: off 0 selects bits [7:0].

## Timing
- Latency: M-stage values appear on the W outputs 1 cycle after the capturing edge. WD_W is valid in the same cycle as A3_W/RegWrite_W, with no extra cycle.
- Reset values: PC_W = 0, A3_W = 0, RegWrite_W = 0, WD_W = 0 (WDSel 0, ALUout 0), Tnew_W = 0.
- Reset mid-stream: the instruction present in M at the reset edge is discarded. The first valid W instruction is the one in M on the first edge with reset low.
- Simultaneous reset and flush: reset result (identical bubble).
- flush for N consecutive cycles yields N bubbles. The cycle after flush deasserts captures M normally.
- DMout_M is sampled at the same edge as ALUout_M. The memory read must be combinational within the M cycle, and this block adds no read latency.

## Test plan
- Reset: drive all inputs nonzero with reset=1 for 2 cycles → all outputs 0. Release: next edge with PC_M=0x3000, ALUout_M=0x12, A3_M=5, RegWrite_M=1, WDSel_M=0 → WD_W=0x12, A3_W=5, RegWrite_W=1, PC_W=0x3000.
- Byte loads: DMout_M=0x80FF7F01, WDSel_M=1, sweep ALUout_M[1:0]=0..3 with lb → WD_W = 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; with lbu → 0x01, 0x7F, 0xFF, 0x80.
- Halfword loads: same DMout_M, ALUout_M offset 0 and 2 (then 3) → lh: 0x00007F01, 0xFFFF80FF (offset 3 same as 2); lhu: 0x00007F01, 0x000080FF.
- Link and wrap: WDSel_M=2 with PC_M=0x00003008 → WD_W=0x00003010. With PC_M=0xFFFFFFFC → WD_W=0x00000004. LoadType 6 with WDSel 1 and DMout 0xDEADBEEF → 0xDEADBEEF.
- $0 suppression: RegWrite_M=1, A3_M=0, ALUout_M=0x55 → RegWrite_W=0, WD_W=0x55.
- Flush/reset priority: flush=1 for 2 cycles during a stream of lw → two bubbles (RegWrite_W=0, A3_W=0, WD_W=0), then normal capture. reset=1 and flush=1 together → all-zero outputs.
